dvi_pixel_stream: RTL and testbench

- Parametrised DVI video timing generator and pixel streamer.
- Pulls pixels from an upstream source (ROM/FIFO path) over a valid/ready interface.
- Generates hsync/vsync/de and presents pixel data either as full-width words, or as two half-width words over two clocks for the 12-bit DDR DVI data bus.
- Sits between the pixel FIFO and the DVI output pins; one instance per display channel.

---
 rtl/dvi_pkg.sv | 19 +
 rtl/dvi_timing_axis.sv | 42 ++++
 rtl/dvi_pixel_stream.sv | 146 ++++++++++++++
 tb/tb_dvi_pixel_stream.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// Shared timing types for the DVI pixel streamer: per-axis timing record, the VGA 640x480 set,
// and a helper that sums an axis into its total period.
package dvi_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  localparam axis_timing_t VGA_640x480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam axis_timing_t VGA_640x480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int unsigned axis_total(axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/dvi_timing_axis.sv
// One timing axis: counter 0..TOTAL-1 advancing on adv, with active/sync decode and a carry-out.
// Decodes are combinational from the counter; clr (run disabled) parks the counter at origin.
module dvi_timing_axis
  import dvi_pkg::*;
#(
  parameter axis_timing_t T = VGA_640x480_H
) (
  input  logic clk,
  input  logic RST,
  input  logic clr,
  input  logic adv,
  output logic active,
  output logic sync_on,
  output logic wrap
);

  localparam int unsigned TOTAL = axis_total(T);
  localparam int unsigned W     = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  // Decode limits carry one spare bit so a zero back porch cannot overflow the end-of-sync bound.
  localparam logic [W:0] LAST    = (W+1)'(TOTAL - 1);
  localparam logic [W:0] ACT_END = (W+1)'(T.active);
  localparam logic [W:0] SYN_BEG = (W+1)'(T.active + T.fp);
  localparam logic [W:0] SYN_END = (W+1)'(T.active + T.fp + T.sync);

  logic [W-1:0] cnt;
  logic [W:0]   cnt_x;

  assign cnt_x   = {1'b0, cnt};
  assign active  = cnt_x < ACT_END;
  assign sync_on = (cnt_x >= SYN_BEG) && (cnt_x < SYN_END);
  assign wrap    = adv && (cnt_x == LAST);

  always_ff @(posedge clk) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dvi_pixel_stream.sv
// DVI timing generator and pixel streamer; outputs registered 1 clk after counter state.
// pix_ready pulses once per active slot regardless of pix_valid; a missing pixel becomes UNDER_COLOR.
module dvi_pixel_stream
  import dvi_pkg::*;
#(
  parameter int unsigned      H_ACTIVE    = VGA_640x480_H.active,
  parameter int unsigned      H_FP        = VGA_640x480_H.fp,
  parameter int unsigned      H_SYNC      = VGA_640x480_H.sync,
  parameter int unsigned      H_BP        = VGA_640x480_H.bp,
  parameter int unsigned      V_ACTIVE    = VGA_640x480_V.active,
  parameter int unsigned      V_FP        = VGA_640x480_V.fp,
  parameter int unsigned      V_SYNC      = VGA_640x480_V.sync,
  parameter int unsigned      V_BP        = VGA_640x480_V.bp,
  parameter bit               HS_POL      = 1'b0,
  parameter bit               VS_POL      = 1'b0,
  parameter int unsigned      PIX_W       = 24,
  parameter bit               HALF_MODE   = 1'b1,
  parameter logic [PIX_W-1:0] UNDER_COLOR = '0
) (
  input  logic                                     clk,
  input  logic                                     RST,
  input  logic                                     en,
  input  logic [PIX_W-1:0]                         pix_data,
  input  logic                                     pix_valid,
  output logic                                     pix_ready,
  input  logic                                     clr_status,
  output logic [(HALF_MODE ? PIX_W/2 : PIX_W)-1:0] d_out,
  output logic                                     de,
  output logic                                     hsync,
  output logic                                     vsync,
  output logic                                     sof,
  output logic                                     underflow,
  output logic [15:0]                              under_cnt
);

  localparam int unsigned  OUT_W = HALF_MODE ? PIX_W/2 : PIX_W;
  localparam axis_timing_t H_T   = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam axis_timing_t V_T   = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

  logic             phase;
  logic             h_adv, h_wrap, v_wrap;
  logic             h_active, v_active, active;
  logic             h_sync_on, v_sync_on;
  logic             at_origin;
  logic [PIX_W-1:0] pix_sel;
  logic [OUT_W-1:0] pix_lo;
  logic [OUT_W-1:0] d_next;

  // In half mode phase 0 presents the high half, phase 1 the low half; counters step after phase 1.
  always_ff @(posedge clk) begin
    if (RST || !en) begin
      phase <= 1'b0;
    end else begin
      phase <= HALF_MODE ? ~phase : 1'b0;
    end
  end

  assign h_adv = en && (phase || !HALF_MODE);

  dvi_timing_axis #(.T(H_T)) u_h (
    .clk     (clk),
    .RST     (RST),
    .clr     (!en),
    .adv     (h_adv),
    .active  (h_active),
    .sync_on (h_sync_on),
    .wrap    (h_wrap)
  );

  dvi_timing_axis #(.T(V_T)) u_v (
    .clk     (clk),
    .RST     (RST),
    .clr     (!en),
    .adv     (h_wrap),
    .active  (v_active),
    .sync_on (v_sync_on),
    .wrap    (v_wrap)
  );

  assign active    = h_active && v_active;
  assign pix_ready = !RST && en && active && !phase;
  assign pix_sel   = pix_valid ? pix_data : UNDER_COLOR;

  always_comb begin
    d_next = '0;
    if (pix_ready) begin
      d_next = pix_sel[PIX_W-1 -: OUT_W];
    end else if (active) begin
      d_next = pix_lo;
    end
  end

  // The next ready slot after a frame wrap (or a restart) is the frame's first pixel.
  always_ff @(posedge clk) begin
    if (RST || !en) begin
      at_origin <= 1'b1;
    end else if (v_wrap) begin
      at_origin <= 1'b1;
    end else if (pix_ready) begin
      at_origin <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pix_lo <= '0;
    end else if (pix_ready) begin
      pix_lo <= pix_sel[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (RST || !en) begin
      d_out <= '0;
      de    <= 1'b0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      sof   <= 1'b0;
    end else begin
      d_out <= d_next;
      de    <= active;
      hsync <= h_sync_on ? HS_POL : ~HS_POL;
      vsync <= v_sync_on ? VS_POL : ~VS_POL;
      sof   <= pix_ready && at_origin;
    end
  end

  // A new underflow outranks a simultaneous clear, so the count restarts at one.
  always_ff @(posedge clk) begin
    if (RST) begin
      underflow <= 1'b0;
      under_cnt <= '0;
    end else if (pix_ready && !pix_valid) begin
      underflow <= 1'b1;
      if (clr_status) begin
        under_cnt <= 16'd1;
      end else if (under_cnt != 16'hFFFF) begin
        under_cnt <= under_cnt + 16'd1;
      end
    end else if (clr_status) begin
      underflow <= 1'b0;
      under_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dvi_pixel_stream.sv
// Bench for dvi_pixel_stream: full-width and half-width instances against a slot-position model.
module tb_dvi_pixel_stream;

  localparam logic [23:0] UNDER = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        RST, en, clr;
  logic [23:0] d0in, d1in;
  logic        v0, v1;
  logic        rdy0, rdy1;
  logic [23:0] do0;
  logic [11:0] do1;
  logic        de0, de1, hs0, hs1, vs0, vs1, sof0, sof1, uf0, uf1;
  logic [15:0] uc0, uc1;

  always #5 clk = ~clk;

  dvi_pixel_stream #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(24), .HALF_MODE(1'b0), .UNDER_COLOR(UNDER)
  ) dut0 (
    .clk(clk), .RST(RST), .en(en), .pix_data(d0in), .pix_valid(v0), .pix_ready(rdy0),
    .clr_status(clr), .d_out(do0), .de(de0), .hsync(hs0), .vsync(vs0), .sof(sof0),
    .underflow(uf0), .under_cnt(uc0)
  );

  dvi_pixel_stream #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(24), .HALF_MODE(1'b1), .UNDER_COLOR(UNDER)
  ) dut1 (
    .clk(clk), .RST(RST), .en(en), .pix_data(d1in), .pix_valid(v1), .pix_ready(rdy1),
    .clr_status(clr), .d_out(do1), .de(de1), .hsync(hs1), .vsync(vs1), .sof(sof1),
    .underflow(uf1), .under_cnt(uc1)
  );

  int errors = 0;
  int checks = 0;
  bit armed  = 0;

  // Model: mk counts enabled clocks since the frame origin; everything follows from that position.
  int          mk[2]    = '{0, 0};
  logic [23:0] mlast[2] = '{24'h0, 24'h0};
  bit          muf[2]   = '{0, 0};
  int          mcnt[2]  = '{0, 0};
  logic [23:0] ed[2]    = '{24'h0, 24'h0};
  bit          ede[2]   = '{0, 0};
  bit          ehs[2]   = '{1, 1};
  bit          evs[2]   = '{1, 1};
  bit          esof[2]  = '{0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_pos(int i, int k);
    return (i == 1) ? k / 2 : k;
  endfunction

  function automatic bit m_act(int i, int k);
    int p;
    p = m_pos(i, k);
    return ((p % 8) < 4) && (((p / 8) % 6) < 3);
  endfunction

  function automatic bit m_rdy(int i);
    return en && !RST && m_act(i, mk[i]) && (i == 0 || (mk[i] % 2) == 0);
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic        vld;
      logic [23:0] dat, px;
      bit          r, act;
      int          p;
      vld = (i == 0) ? v0 : v1;
      dat = (i == 0) ? d0in : d1in;
      r   = m_rdy(i);
      p   = m_pos(i, mk[i]);
      act = m_act(i, mk[i]);
      if (RST) begin
        ed[i] = 24'h0; ede[i] = 0; ehs[i] = 1; evs[i] = 1; esof[i] = 0;
        muf[i] = 0; mcnt[i] = 0; mk[i] = 0;
      end else begin
        if (r && !vld) begin
          muf[i]  = 1;
          mcnt[i] = clr ? 1 : ((mcnt[i] < 65535) ? mcnt[i] + 1 : mcnt[i]);
        end else if (clr) begin
          muf[i] = 0; mcnt[i] = 0;
        end
        if (!en) begin
          ed[i] = 24'h0; ede[i] = 0; ehs[i] = 1; evs[i] = 1; esof[i] = 0;
          mk[i] = 0;
        end else begin
          if (r) begin
            px       = vld ? dat : UNDER;
            mlast[i] = px;
            ed[i]    = (i == 1) ? {12'h0, px[23:12]} : px;
          end else if (act) begin
            ed[i] = {12'h0, mlast[i][11:0]};
          end else begin
            ed[i] = 24'h0;
          end
          ede[i]  = act;
          ehs[i]  = !(((p % 8) == 5) || ((p % 8) == 6));
          evs[i]  = ((p / 8) % 6) != 4;
          esof[i] = r && ((p % 48) == 0);
          mk[i]++;
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic [23:0] ad;
      logic        ar, ade, ahs, avs, asof, auf;
      logic [15:0] ac;
      ad   = (i == 0) ? do0 : {12'h0, do1};
      ar   = (i == 0) ? rdy0 : rdy1;
      ade  = (i == 0) ? de0 : de1;
      ahs  = (i == 0) ? hs0 : hs1;
      avs  = (i == 0) ? vs0 : vs1;
      asof = (i == 0) ? sof0 : sof1;
      auf  = (i == 0) ? uf0 : uf1;
      ac   = (i == 0) ? uc0 : uc1;
      chk($sformatf("d_out[%0d]", i),     32'(ad),   32'(ed[i]));
      chk($sformatf("pix_ready[%0d]", i), 32'(ar),   32'(m_rdy(i)));
      chk($sformatf("de[%0d]", i),        32'(ade),  32'(ede[i]));
      chk($sformatf("hsync[%0d]", i),     32'(ahs),  32'(ehs[i]));
      chk($sformatf("vsync[%0d]", i),     32'(avs),  32'(evs[i]));
      chk($sformatf("sof[%0d]", i),       32'(asof), 32'(esof[i]));
      chk($sformatf("underflow[%0d]", i), 32'(auf),  32'(muf[i]));
      chk($sformatf("under_cnt[%0d]", i), 32'(ac),   32'(mcnt[i][15:0]));
    end
  endtask

  // One clock: compare on the falling edge, step the model at the rising edge, then advance the source.
  task automatic tick();
    bit go0;
    @(negedge clk);
    if (armed) compare();
    go0 = m_rdy(0) && v0;
    @(posedge clk);
    model_step();
    armed = 1;
    #1;
    if (go0) d0in = d0in + 24'd1;
  endtask

  initial begin
    int          n_sof0, n_sof1, last0, last1, gap0, gap1;
    logic [23:0] nx;
    n_sof0 = 0; n_sof1 = 0; last0 = 0; last1 = 0; gap0 = 0; gap1 = 0;
    RST = 1'b1; en = 1'b1; clr = 1'b0;
    v0 = 1'b1; v1 = 1'b1; d0in = 24'h000001; d1in = 24'hABC123;
    repeat (3) tick();
    chk("rst_d_out",  32'(do0), 32'h0);
    chk("rst_de",     32'(de0), 32'h0);
    chk("rst_hsync",  32'(hs0), 32'h1);
    chk("rst_vsync",  32'(vs0), 32'h1);
    chk("rst_cnt",    32'(uc0), 32'h0);
    chk("rst_ready",  32'(rdy0), 32'h0);

    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 4) begin
        chk("line0_data", 32'(do0), 32'(i + 1));
        chk("line0_de",   32'(de0), 32'h1);
      end else begin
        chk("line0_blank", 32'(de0), 32'h0);
      end
      if (i == 0) begin
        chk("first_sof",  32'(sof0), 32'h1);
        chk("half_hi",    32'(do1),  32'hABC);
        chk("half_hi_de", 32'(de1),  32'h1);
      end
      if (i == 1) begin
        chk("half_lo",    32'(do1), 32'h123);
        chk("half_lo_de", 32'(de1), 32'h1);
      end
      if (i == 4) chk("hsync_pre",  32'(hs0), 32'h1);
      if (i == 5) chk("hsync_on5",  32'(hs0), 32'h0);
      if (i == 6) chk("hsync_on6",  32'(hs0), 32'h0);
      if (i == 7) chk("hsync_post", 32'(hs0), 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("line1_data", 32'(do0), 32'(i + 5));
    end

    // Free run to t=200 ticks after release, logging sof spacing per instance.
    n_sof0 = 1; n_sof1 = 1; last0 = 1; last1 = 1;
    for (int t = 13; t <= 200; t++) begin
      tick();
      if (sof0) begin gap0 = t - last0; last0 = t; n_sof0++; end
      if (sof1) begin gap1 = t - last1; last1 = t; n_sof1++; end
      if (t == 32) chk("vsync_before", 32'(vs0), 32'h1);
      if (t == 33) chk("vsync_first",  32'(vs0), 32'h0);
      if (t == 40) chk("vsync_last",   32'(vs0), 32'h0);
      if (t == 41) chk("vsync_after",  32'(vs0), 32'h1);
    end
    chk("sof_gap_full", 32'(gap0),   32'd48);
    chk("sof_cnt_full", 32'(n_sof0), 32'd5);
    chk("sof_gap_half", 32'(gap1),   32'd96);
    chk("sof_cnt_half", 32'(n_sof1), 32'd3);

    // Run-enable low mid-frame.
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("enlow_ready", 32'(rdy0), 32'h0);
      chk("enlow_hsync", 32'(hs0),  32'h1);
      chk("enlow_vsync", 32'(vs0),  32'h1);
      chk("enlow_de",    32'(de0),  32'h0);
    end
    en = 1'b1;
    nx = d0in;
    tick();
    chk("restart_sof",   32'(sof0), 32'h1);
    chk("restart_data",  32'(do0),  32'(nx));
    chk("restart_sof_h", 32'(sof1), 32'h1);
    chk("restart_hi_h",  32'(do1),  32'hABC);
    tick();

    // Underflow on slots 2 and 3 of line 0.
    v0 = 1'b0;
    tick();
    chk("uf_color", 32'(do0), 32'(UNDER));
    chk("uf_flag",  32'(uf0), 32'h1);
    chk("uf_cnt1",  32'(uc0), 32'h1);
    tick();
    chk("uf_cnt2",  32'(uc0), 32'h2);
    v0 = 1'b1;
    nx = d0in;
    tick();
    clr = 1'b1;
    tick();
    chk("clr_flag", 32'(uf0), 32'h0);
    chk("clr_cnt",  32'(uc0), 32'h0);
    clr = 1'b0;
    tick();
    tick();
    tick();
    chk("resume_data", 32'(do0), 32'(nx));
    tick();
    v0 = 1'b0; clr = 1'b1;
    tick();
    chk("setwins_flag", 32'(uf0), 32'h1);
    chk("setwins_cnt",  32'(uc0), 32'h1);
    v0 = 1'b1; clr = 1'b0;
    tick();
    tick();

    // Reset mid line 1.
    RST = 1'b1;
    tick();
    chk("midrst_d_out", 32'(do0),  32'h0);
    chk("midrst_de",    32'(de0),  32'h0);
    chk("midrst_hsync", 32'(hs0),  32'h1);
    chk("midrst_vsync", 32'(vs0),  32'h1);
    chk("midrst_sof",   32'(sof0), 32'h0);
    chk("midrst_uf",    32'(uf0),  32'h0);
    chk("midrst_cnt",   32'(uc0),  32'h0);
    chk("midrst_ready", 32'(rdy0), 32'h0);
    chk("midrst_d1",    32'(do1),  32'h0);
    RST = 1'b0;
    nx = d0in;
    tick();
    chk("postrst_sof",  32'(sof0), 32'h1);
    chk("postrst_data", 32'(do0),  32'(nx));
    chk("postrst_de",   32'(de0),  32'h1);
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
